// File: rtl/cam_capture_stream.sv
// Camera capture front end: registers the sensor bus, frames on Vsyn/Href,
// assembles BPP-byte pixels, crops to H_ACT x V_ACT and streams them through
// a show-ahead FIFO tagged with start-of-frame / end-of-line bits.
//
// state | meaning
// IDLE  | not capturing, waiting for capture request
// SYNC  | capture requested, waiting for Vsyn high (frame boundary)
// ARM   | between frames, waiting for Vsyn falling edge
// CAPT  | frame in progress, pixels assembled and pushed
// DONE  | one-cycle frame wrap-up: pulse, count, frame length check
module cam_capture_stream #(
  parameter int  DATA_W     = 8,
  parameter int  BPP        = 2,
  parameter int  H_ACT      = 640,
  parameter int  V_ACT      = 480,
  parameter int  FIFO_DEPTH = 16,
  localparam int PIX_W      = DATA_W * BPP
) (
  input  logic              Pclk,
  input  logic              rst,
  input  logic              capture,
  input  logic              Vsyn,
  input  logic              Href,
  input  logic [DATA_W-1:0] data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  output logic              line_err,
  output logic              frame_err
);

  localparam int XW = $clog2(H_ACT + 2);
  localparam int YW = $clog2(V_ACT + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACT);
  localparam logic [XW-1:0] X_SAT  = XW'(H_ACT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACT);
  localparam logic [YW-1:0] Y_SAT  = YW'(V_ACT + 1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ARM, S_CAPT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_data;
  logic              r_href, r_href_d, r_vsyn, r_vsyn_d;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [15:0]       r_frame_cnt;
  logic              r_overflow, r_line_err, r_frame_err;
  logic [PIX_W+1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;

  logic              w_vsyn_rise, w_vsyn_fall, w_href_fall;
  logic              w_start, w_clr_frame, w_line_end, w_byte_en;
  logic              w_pix_done, w_in_win, w_push, w_pop, w_wr;
  logic              w_empty, w_full;
  logic [PIX_W-1:0]  w_pixel;
  logic [PIX_W+1:0]  w_head;

  // Register the sensor bus once and keep the previous sync levels for edges
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_vsyn   <= 1'b0;
      r_vsyn_d <= 1'b0;
    end else begin
      r_data   <= data;
      r_href   <= Href;
      r_href_d <= r_href;
      r_vsyn   <= Vsyn;
      r_vsyn_d <= r_vsyn;
    end
  end

  assign w_vsyn_rise = r_vsyn & ~r_vsyn_d;
  assign w_vsyn_fall = ~r_vsyn & r_vsyn_d;
  assign w_href_fall = ~r_href & r_href_d;

  assign w_start     = (r_state == S_IDLE) & capture;
  assign w_clr_frame = (r_state == S_ARM) & w_vsyn_fall;
  assign w_line_end  = (r_state == S_CAPT) & w_href_fall;
  assign w_byte_en   = (r_state == S_CAPT) & r_href;

  // State register
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a dropped capture only takes effect in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (capture)     w_next = S_SYNC;
      S_SYNC: if (r_vsyn)      w_next = S_ARM;
      S_ARM:  if (w_vsyn_fall) w_next = S_CAPT;
      S_CAPT: if (w_vsyn_rise) w_next = S_DONE;
      S_DONE: w_next = capture ? S_ARM : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  generate
    if (BPP == 2) begin : g_two
      logic [DATA_W-1:0] r_hi;
      logic              r_phase;
      // Byte phase: first byte of a pixel is held as the high half
      always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
          r_hi    <= '0;
          r_phase <= 1'b0;
        end else if (w_clr_frame || w_line_end) begin
          r_phase <= 1'b0;
        end else if (w_byte_en) begin
          if (!r_phase) r_hi <= r_data;
          r_phase <= ~r_phase;
        end
      end
      assign w_pix_done = w_byte_en & r_phase;
      assign w_pixel    = {r_hi, r_data};
    end else begin : g_one
      assign w_pix_done = w_byte_en;
      assign w_pixel    = r_data;
    end
  endgenerate

  // Pixel and line position, both saturating one past the window
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_clr_frame) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_line_end) begin
      r_x <= '0;
      if (r_y != Y_SAT) r_y <= r_y + YW'(1);
    end else if (w_pix_done && (r_x != X_SAT)) begin
      r_x <= r_x + XW'(1);
    end
  end

  assign w_in_win = (r_x < X_ACT) & (r_y < Y_ACT);
  assign w_push   = w_pix_done & w_in_win;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = ~w_empty & pix_ready;
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage: tag bits above the pixel
  always_ff @(posedge Pclk) begin
    if (w_wr)
      r_mem[r_wr_ptr[AW-1:0]] <= {(r_x == '0) && (r_y == '0), r_x == X_LAST, w_pixel};
  end

  // FIFO pointers; only reset empties the FIFO
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Sticky status flags and the completed-frame counter
  always_ff @(posedge Pclk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start) begin
        r_overflow  <= 1'b0;
        r_line_err  <= 1'b0;
        r_frame_err <= 1'b0;
      end else begin
        if (w_push && w_full && !w_pop)         r_overflow  <= 1'b1;
        if (w_line_end && (r_x != X_ACT))       r_line_err  <= 1'b1;
        if ((r_state == S_DONE) && (r_y != Y_ACT)) r_frame_err <= 1'b1;
      end
      if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign pix_valid  = ~w_empty;
  assign pix_data   = w_empty ? '0 : w_head[PIX_W-1:0];
  assign pix_eol    = ~w_empty & w_head[PIX_W];
  assign pix_sof    = ~w_empty & w_head[PIX_W+1];
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign frame_cnt  = r_frame_cnt;
  assign overflow   = r_overflow;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_cam_capture_stream.sv
// Bench for cam_capture_stream with a small 4x2 window and a 4-deep FIFO.
// Expected pixels come from a frame-level model: each line's bytes are paired
// into pixels and kept only inside the window.
module tb_cam_capture_stream;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 4;
  localparam int PW = 16;

  logic          Pclk = 1'b0;
  logic          rst = 1'b1;
  logic          capture = 1'b0;
  logic          Vsyn = 1'b0;
  logic          Href = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          pix_ready = 1'b1;
  logic [PW-1:0] pix_data;
  logic          pix_sof, pix_eol, pix_valid;
  logic          busy, frame_done, overflow, line_err, frame_err;
  logic [15:0]   frame_cnt;

  cam_capture_stream #(
    .DATA_W(8), .BPP(2), .H_ACT(H), .V_ACT(V), .FIFO_DEPTH(D)
  ) dut (
    .Pclk(Pclk), .rst(rst), .capture(capture), .Vsyn(Vsyn), .Href(Href),
    .data(data), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    int nl; int l0; int l1; int l2; bit le; bit fe; int np;
  } vec_t;

  vec_t          vt[7];
  int            checks = 0, failures = 0, rx_cnt = 0, done_cnt = 0;
  logic [PW+1:0] exp_q[$];
  logic [PW+1:0] m_e;
  logic [7:0]    byte_q[$];
  int            line_len[4];
  int            n_lines, bp, r0, d0, n_exp;
  bit            m_le, m_fe;
  logic [15:0]   exp_fc = 16'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Consumer side: every accepted pixel is compared with the model queue
  always @(negedge Pclk) begin
    if (!rst && pix_valid && pix_ready) begin
      checks++;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pixel got=%h", {pix_sof, pix_eol, pix_data});
      end else begin
        m_e = exp_q.pop_front();
        if ({pix_sof, pix_eol, pix_data} !== m_e) begin
          failures++;
          $display("FAIL pixel got=%h exp=%h", {pix_sof, pix_eol, pix_data}, m_e);
        end
      end
    end
    if (!rst && frame_done) done_cnt++;
  end

  task automatic drive(input logic [7:0] d, input logic h, input logic v);
    @(posedge Pclk);
    #1;
    data = d;
    Href = h;
    Vsyn = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, Vsyn);
  endtask

  // Frame model: pair bytes per line, crop to the window, derive flags
  task automatic model();
    int idx = 0;
    m_le = 1'b0;
    m_fe = (n_lines != V);
    for (int y = 0; y < n_lines; y++) begin
      int np = line_len[y] / 2;
      if (np != H) m_le = 1'b1;
      for (int p = 0; p < np; p++)
        if (p < H && y < V)
          exp_q.push_back({(p == 0) && (y == 0), p == H - 1,
                           byte_q[idx + 2*p], byte_q[idx + 2*p + 1]});
      idx += line_len[y];
    end
  endtask

  task automatic build(input int nl, input int l0, input int l1, input int l2, input bit rnd);
    int total;
    n_lines = nl;
    line_len[0] = l0; line_len[1] = l1; line_len[2] = l2; line_len[3] = 0;
    byte_q.delete();
    bp = 0;
    total = 0;
    for (int l = 0; l < nl; l++) total += line_len[l];
    for (int i = 0; i < total; i++)
      byte_q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    model();
  endtask

  task automatic send_line(input int len, input bit lat);
    for (int i = 0; i < len; i++) begin
      drive(byte_q[bp], 1'b1, 1'b0);
      bp++;
      if (lat && i == 2) check("pix_latency_before", 32'(pix_valid), 0);
      if (lat && i == 3) check("pix_latency_after", 32'(pix_valid), 1);
    end
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input bit drop, input bit lat, input int gap);
    repeat (4) drive(8'h00, 1'b0, 1'b1);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    if (drop) capture = 1'b0;
    for (int l = 0; l < n_lines; l++) begin
      send_line(line_len[l], lat && (l == 0));
      repeat (gap) drive(8'h00, 1'b0, 1'b0);
    end
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_done(input int dstart, input string name);
    int n = 0;
    while (done_cnt == dstart && n < 20) begin
      @(posedge Pclk);
      n++;
    end
    #1;
    check(name, 32'(done_cnt - dstart), 1);
    exp_fc = exp_fc + 16'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vt[0] = '{2, 8, 8, 0, 1'b0, 1'b0, 8};
    vt[1] = '{2, 10, 8, 0, 1'b1, 1'b0, 8};
    vt[2] = '{2, 6, 8, 0, 1'b1, 1'b0, 7};
    vt[3] = '{3, 8, 8, 8, 1'b0, 1'b1, 8};
    vt[4] = '{1, 8, 0, 0, 1'b0, 1'b1, 4};
    vt[5] = '{2, 8, 12, 0, 1'b1, 1'b0, 8};
    vt[6] = '{0, 0, 0, 0, 1'b0, 1'b1, 0};

    // Reset state, during and after reset
    repeat (3) @(posedge Pclk);
    #1;
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_flags", 32'({overflow, line_err, frame_err, frame_done}), 0);
    rst = 1'b0;
    idle(2);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_data", 32'({pix_data, pix_sof, pix_eol, pix_valid}), 0);

    // Table of single frames, each started from IDLE
    for (int i = 0; i < 7; i++) begin
      idle(3);
      capture = 1'b1;
      r0 = rx_cnt;
      build(vt[i].nl, vt[i].l0, vt[i].l1, vt[i].l2, 1'b0);
      run_frame(1'b1, 1'b0, 2);
      wait_done(done_cnt, $sformatf("vec%0d_frame_done", i));
      idle(6);
      check($sformatf("vec%0d_line_err", i), 32'(line_err), 32'(vt[i].le));
      check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vt[i].fe));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 0);
      check($sformatf("vec%0d_pix_count", i), 32'(rx_cnt - r0), 32'(vt[i].np));
      check($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(exp_fc));
      check($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end

    // Capture requested mid-frame: nothing until the next Vsyn high-to-low
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    capture = 1'b1;
    r0 = rx_cnt;
    for (int i = 0; i < 8; i++) drive(8'(8'hA0 + i), 1'b1, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    check("midframe_no_pix", 32'(pix_valid), 0);
    check("midframe_busy", 32'(busy), 1);
    build(2, 8, 8, 0, 1'b1);
    run_frame(1'b1, 1'b0, 1);
    wait_done(done_cnt, "midframe_done");
    idle(6);
    check("midframe_pix_count", 32'(rx_cnt - r0), 8);

    // Overflow with a stalled consumer, then drain in order
    idle(3);
    pix_ready = 1'b0;
    capture = 1'b1;
    r0 = rx_cnt;
    build(2, 8, 8, 0, 1'b0);
    run_frame(1'b1, 1'b1, 2);
    wait_done(done_cnt, "ovf_done");
    idle(2);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_valid", 32'(pix_valid), 1);
    check("ovf_no_len_err", 32'({line_err, frame_err}), 0);
    while (exp_q.size() > D) void'(exp_q.pop_back());
    pix_ready = 1'b1;
    idle(8);
    check("ovf_drain_count", 32'(rx_cnt - r0), D);
    check("ovf_drain_empty", 32'(pix_valid), 0);

    // Continuous capture: frame_done latency on the first frame
    idle(3);
    capture = 1'b1;
    d0 = done_cnt;
    r0 = rx_cnt;
    build(2, 8, 8, 0, 1'b1);
    run_frame(1'b0, 1'b0, 1);
    @(negedge Pclk);
    check("fd_lat_n0", 32'(frame_done), 0);
    @(negedge Pclk);
    check("fd_lat_n1", 32'(frame_done), 0);
    @(negedge Pclk);
    check("fd_lat_n2", 32'(frame_done), 1);
    check("fc_before_inc", 32'(frame_cnt), 32'(exp_fc));
    exp_fc = exp_fc + 16'd1;
    @(negedge Pclk);
    check("fd_lat_n3", 32'(frame_done), 0);
    check("fc_after_inc", 32'(frame_cnt), 32'(exp_fc));
    for (int f = 0; f < 2; f++) begin
      build(2, 8, 8, 0, 1'b1);
      run_frame(1'b0, 1'b0, 2);
      wait_done(done_cnt, $sformatf("cont%0d_done", f + 1));
    end
    idle(4);
    check("cont_done_pulses", 32'(done_cnt - d0), 3);
    check("cont_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    check("cont_busy", 32'(busy), 1);
    build(2, 8, 8, 0, 1'b1);
    run_frame(1'b1, 1'b0, 1);
    wait_done(done_cnt, "drop_done");
    idle(6);
    check("drop_busy", 32'(busy), 0);
    check("drop_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    check("cont_pix_count", 32'(rx_cnt - r0), 32);

    // Reset mid-line with pixels waiting in the FIFO
    idle(3);
    pix_ready = 1'b0;
    capture = 1'b1;
    build(2, 2, 8, 0, 1'b0);
    exp_q.delete();
    repeat (4) drive(8'h00, 1'b0, 1'b1);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    send_line(2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(byte_q[bp], 1'b1, 1'b0);
      bp++;
    end
    check("pre_rst_valid", 32'(pix_valid), 1);
    check("pre_rst_line_err", 32'(line_err), 1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(pix_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    check("mid_rst_flags", 32'({overflow, line_err, frame_err, frame_done}), 0);
    Href = 1'b0;
    Vsyn = 1'b0;
    capture = 1'b0;
    exp_fc = 16'd0;
    @(posedge Pclk);
    #1;
    rst = 1'b0;
    pix_ready = 1'b1;
    idle(3);
    check("after_rst_busy", 32'(busy), 0);
    check("after_rst_valid", 32'(pix_valid), 0);

    // Randomized frames against the model
    for (int t = 0; t < 25; t++) begin
      idle($urandom_range(2, 4));
      capture = 1'b1;
      r0 = rx_cnt;
      build($urandom_range(0, 3), 2 * $urandom_range(1, 6),
            2 * $urandom_range(1, 6), 2 * $urandom_range(1, 6), 1'b1);
      n_exp = exp_q.size();
      run_frame(1'b1, 1'b0, $urandom_range(0, 2));
      wait_done(done_cnt, $sformatf("rnd%0d_done", t));
      idle(8);
      check($sformatf("rnd%0d_line_err", t), 32'(line_err), 32'(m_le));
      check($sformatf("rnd%0d_frame_err", t), 32'(frame_err), 32'(m_fe));
      check($sformatf("rnd%0d_overflow", t), 32'(overflow), 0);
      check($sformatf("rnd%0d_pix_count", t), 32'(rx_cnt - r0), 32'(n_exp));
      check($sformatf("rnd%0d_frame_cnt", t), 32'(frame_cnt), 32'(exp_fc));
      check($sformatf("rnd%0d_busy", t), 32'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
